// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of a word-only data memory.
// Sub-word stores run as read-modify-write. Every transaction ends with a one-cycle ack on its port.
module dm_arbiter #(
  parameter int   ADDR_W     = 12,
  parameter logic RESET_LAST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [1:0]        size0,
  input  logic [1:0]        size1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  input  logic [31:0]       dm_data_out,
  output logic              ack0,
  output logic              ack1,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              dm_in_enable,
  output logic              dm_out_enable
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RMW_RD, RMW_CAP, RMW_WR, ACK} state_t;

  state_t              state_r, state_s;
  logic                gnt_r, gnt_s, last_gnt_r, last_gnt_s;
  logic                we_r, we_s, bad_r, bad_s;
  logic [1:0]          size_r, size_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [31:0]         wdata_r, wdata_s, merge_r, merge_s, rdata_s;
  logic                pick_s, sel_we_s, sel_bad_s;
  logic [1:0]          sel_size_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [31:0]         sel_wdata_s;
  logic                ack0_s, ack1_s, err_s, busy_s, dm_in_s, dm_out_s;
  logic [ADDR_W-3:0]   dm_addr_s;
  logic [31:0]         dm_wdata_s;

  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   is_bad = 1'b0;
      2'b01:   is_bad = lo[0];
      2'b10:   is_bad = (lo != 2'b00);
      default: is_bad = 1'b1;
    endcase
  endfunction

  // Big-endian lane replacement: byte 0 and the low halfword address land in the MSBs.
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [1:0] lo);
    merge_lane = word;
    if (size == 2'b00) begin
      case (lo)
        2'b00:   merge_lane = {wd[7:0], word[23:0]};
        2'b01:   merge_lane = {word[31:24], wd[7:0], word[15:0]};
        2'b10:   merge_lane = {word[31:16], wd[7:0], word[7:0]};
        default: merge_lane = {word[31:8], wd[7:0]};
      endcase
    end else if (size == 2'b01) begin
      merge_lane = lo[1] ? {word[31:16], wd[15:0]} : {wd[15:0], word[15:0]};
    end else begin
      merge_lane = word;
    end
  endfunction

  // Next-state, latched request fields and next registered outputs.
  always_comb begin
    state_s    = state_r;
    gnt_s      = gnt_r;
    last_gnt_s = last_gnt_r;
    we_s       = we_r;
    size_s     = size_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    bad_s      = bad_r;
    merge_s    = merge_r;
    rdata_s    = rdata;

    if (req0 && req1) begin
      pick_s = ~last_gnt_r;
    end else begin
      pick_s = req1;
    end
    sel_we_s    = pick_s ? we1 : we0;
    sel_size_s  = pick_s ? size1 : size0;
    sel_addr_s  = pick_s ? addr1 : addr0;
    sel_wdata_s = pick_s ? wdata1 : wdata0;
    sel_bad_s   = is_bad(sel_size_s, sel_addr_s[1:0]);

    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          gnt_s      = pick_s;
          last_gnt_s = pick_s;
          we_s       = sel_we_s;
          size_s     = sel_size_s;
          addr_s     = sel_addr_s;
          wdata_s    = sel_wdata_s;
          bad_s      = sel_bad_s;
          if (sel_bad_s) begin
            state_s = ACK;
          end else if (!sel_we_s) begin
            state_s = RD;
          end else if (sel_size_s == 2'b10) begin
            state_s = WR;
          end else begin
            state_s = RMW_RD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD:      state_s = CAP;
      CAP: begin
        rdata_s = dm_data_out;
        state_s = ACK;
      end
      WR:      state_s = ACK;
      RMW_RD:  state_s = RMW_CAP;
      RMW_CAP: begin
        merge_s = merge_lane(dm_data_out, wdata_r, size_r, addr_r[1:0]);
        state_s = RMW_WR;
      end
      RMW_WR:  state_s = ACK;
      ACK:     state_s = IDLE;
      default: state_s = IDLE;
    endcase

    ack0_s     = (state_s == ACK) && !gnt_s;
    ack1_s     = (state_s == ACK) && gnt_s;
    err_s      = (state_s == ACK) && bad_s;
    busy_s     = (state_s != IDLE);
    dm_out_s   = (state_s == RD) || (state_s == CAP) || (state_s == RMW_RD) || (state_s == RMW_CAP);
    dm_in_s    = (state_s == WR) || (state_s == RMW_WR);
    dm_addr_s  = (dm_out_s || dm_in_s) ? addr_s[ADDR_W-1:2] : {(ADDR_W-2){1'b0}};
    if (state_s == WR) begin
      dm_wdata_s = wdata_s;
    end else if (state_s == RMW_WR) begin
      dm_wdata_s = merge_s;
    end else begin
      dm_wdata_s = 32'h0000_0000;
    end
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      gnt_r         <= 1'b0;
      last_gnt_r    <= RESET_LAST;
      we_r          <= 1'b0;
      size_r        <= 2'b00;
      addr_r        <= {ADDR_W{1'b0}};
      wdata_r       <= 32'h0000_0000;
      bad_r         <= 1'b0;
      merge_r       <= 32'h0000_0000;
      rdata         <= 32'h0000_0000;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
      dm_addr       <= {(ADDR_W-2){1'b0}};
      dm_wdata      <= 32'h0000_0000;
      dm_in_enable  <= 1'b0;
      dm_out_enable <= 1'b0;
    end else begin
      state_r       <= state_s;
      gnt_r         <= gnt_s;
      last_gnt_r    <= last_gnt_s;
      we_r          <= we_s;
      size_r        <= size_s;
      addr_r        <= addr_s;
      wdata_r       <= wdata_s;
      bad_r         <= bad_s;
      merge_r       <= merge_s;
      rdata         <= rdata_s;
      ack0          <= ack0_s;
      ack1          <= ack1_s;
      err           <= err_s;
      busy          <= busy_s;
      dm_addr       <= dm_addr_s;
      dm_wdata      <= dm_wdata_s;
      dm_in_enable  <= dm_in_s;
      dm_out_enable <= dm_out_s;
    end
  end

endmodule
